fetch_controller: RTL and testbench



---
 rtl/fetch_controller_pkg.sv | 24 ++
 rtl/fetch_controller.sv | 120 ++++++++++++
 tb/tb_fetch_controller.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller:
// datapath width, default parameters, FSM state encoding and a PC helper.
package fetch_controller_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_PC_STEP   = 32'd4;
  localparam logic [XLEN-1:0] DEF_HALT_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one read at a time to
// instruction memory, holds each fetched word for decode, and handles
// redirects (with drop of an in-flight response) and halt-on-end-word.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] PC_STEP   = DEF_PC_STEP,
  parameter logic [XLEN-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  output logic            halted
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_drop;   // the outstanding response belongs to a stale PC

  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_seq_pc;

  assign w_redir_pc = align_pc(redirect_pc);
  assign w_seq_pc   = r_pc + PC_STEP;

  // The request address is the PC register itself, so it follows any
  // redirect taken while a request is still waiting for mem_ready.
  assign mem_addr = r_pc;

  // Fetch FSM; redirect takes priority over every other event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= align_pc(RESET_PC);
      r_drop   <= 1'b0;
      mem_req  <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= align_pc(RESET_PC);
      halted   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (redirect) r_pc <= w_redir_pc;
          mem_req <= 1'b1;
          r_state <= S_REQ;
        end

        S_REQ: begin
          if (redirect) r_pc <= w_redir_pc;
          if (mem_ready) begin
            // A redirect on the accept cycle makes the response stale.
            mem_req <= 1'b0;
            r_drop  <= redirect;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect) r_pc <= w_redir_pc;
          if (mem_rvalid) begin
            r_drop <= 1'b0;
            if (r_drop || redirect) begin
              mem_req <= 1'b1;
              r_state <= S_REQ;
            end else if (mem_rdata == HALT_WORD) begin
              halted  <= 1'b1;
              r_state <= S_HALT;
            end else begin
              if_instr <= mem_rdata;
              if_pc    <= r_pc;
              if_valid <= 1'b1;
              r_state  <= S_HOLD;
            end
          end else if (redirect) begin
            r_drop <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect kills the held word even when decode takes it.
          if (redirect) begin
            r_pc     <= w_redir_pc;
            if_valid <= 1'b0;
            mem_req  <= 1'b1;
            r_state  <= S_REQ;
          end else if (if_ready) begin
            r_pc     <= w_seq_pc;
            if_valid <= 1'b0;
            mem_req  <= 1'b1;
            r_state  <= S_REQ;
          end
        end

        S_HALT: begin
          if (redirect) begin
            r_pc    <= w_redir_pc;
            halted  <= 1'b0;
            mem_req <= 1'b1;
            r_state <= S_REQ;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: bench-side instruction memory with variable
// latency, a transaction-level reference model (architectural PC, pending
// decode beat, halt flag), directed scenarios and a randomized phase.
module tb_fetch_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        halted;

  fetch_controller dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // stimulus knobs
  bit          k_rst_n = 1'b0;
  bit          k_redir = 1'b0;
  logic [31:0] k_tgt   = 32'h0;
  bit          k_rdy   = 1'b0;
  bit          rnd     = 1'b0;
  int          rdy_pct = 100;
  int          spur_pct = 0;
  int          lat     = 1;
  bit          force_en = 1'b0;
  logic [31:0] force_word = 32'h0;
  bit          halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;
  int          n_beats = 0;

  // bench memory
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pdata = 32'h0;
  bit          just_acc = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  // reference model
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_bpc = 32'h0;
  logic [31:0] m_bword = 32'h0;
  logic [31:0] m_raddr = 32'h0;
  bit          m_halted = 1'b0;
  bit          m_beat = 1'b0;
  bit          m_out = 1'b0;
  bit          m_live = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (force_en) return force_word;
    if (halt_en && a == halt_addr) return 32'h0;
    return ((a * 32'h9E37_79B1) ^ 32'h0000_0013) | 32'h1;
  endfunction

  // Advance the model across the coming edge given the driven inputs.
  task automatic model_update();
    logic [31:0] t;
    if (!reset) begin
      m_pc = 32'h0; m_halted = 1'b0; m_beat = 1'b0; m_out = 1'b0; m_live = 1'b0;
      return;
    end
    t = redirect_pc & 32'hFFFF_FFFC;
    if (m_beat && if_ready && !redirect) begin
      m_beat = 1'b0;
      m_pc   = m_pc + 32'd4;
    end
    if (mem_rvalid && m_out) begin
      m_out = 1'b0;
      if (m_live && !redirect) begin
        if (mem_rdata == 32'h0) m_halted = 1'b1;
        else begin
          m_beat = 1'b1; m_bpc = m_raddr; m_bword = mem_rdata;
        end
      end
      m_live = 1'b0;
    end
    if (redirect) begin
      m_pc = t; m_halted = 1'b0; m_beat = 1'b0; m_live = 1'b0;
    end
    if (mem_req === 1'b1 && mem_ready) begin
      m_out = 1'b1; m_live = !redirect; m_raddr = mem_addr;
    end
  endtask

  task automatic check_model();
    chk("halted", halted, m_halted);
    chk("if_valid", if_valid, m_beat);
    if (m_beat) begin
      chk("if_pc", if_pc, m_bpc);
      chk("if_instr", if_instr, m_bword);
    end
    if (mem_req === 1'b1) chk("mem_addr", mem_addr, m_pc);
    if (m_out || m_beat || m_halted) chk("no_req", mem_req, 1'b0);
  endtask

  // Drive one cycle of inputs, step the model, cross the edge, then check.
  task automatic step();
    bit          deliver;
    bit          acc;
    logic [31:0] a;
    deliver    = pend && (cnt == 0);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (deliver) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pdata;
    end else if (!pend && int'($urandom_range(99)) < spur_pct) begin
      mem_rvalid = 1'b1;
    end
    mem_ready = (int'($urandom_range(99)) < rdy_pct);
    reset     = k_rst_n;
    if (rnd) begin
      redirect    = (int'($urandom_range(99)) < 8);
      redirect_pc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : 32'($urandom_range(255));
      if_ready    = (int'($urandom_range(99)) < 60);
    end else begin
      redirect    = k_redir;
      redirect_pc = k_tgt;
      if_ready    = k_rdy;
      k_redir     = 1'b0;
    end
    if (reset && m_beat && if_ready && !redirect) n_beats++;
    model_update();
    acc = reset && (mem_req === 1'b1) && mem_ready;
    a   = mem_addr;
    @(posedge clock);
    #1;
    if (deliver) pend = 1'b0;
    else if (pend && cnt > 0) cnt--;
    just_acc = acc;
    acc_addr = a;
    if (acc) begin
      pend  = 1'b1;
      cnt   = rnd ? int'($urandom_range(2)) : lat - 1;
      pdata = mem_word(a);
    end
    check_model();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_if_valid"}, if_valid, 1'b0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_halted"}, halted, 1'b0);
  endtask

  initial begin
    int          req_at;
    int          val_at;
    int          nacc;
    logic [31:0] accs [3];
    logic [31:0] hp;
    logic [31:0] hi;

    // 1: reset, zero-wait memory returning a NOP everywhere
    rdy_pct = 100; lat = 1; force_en = 1'b1; force_word = 32'h0000_0013; k_rdy = 1'b1;
    k_rst_n = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    k_rst_n = 1'b1;
    req_at = 0; val_at = 0; nacc = 0;
    for (int i = 1; i <= 40 && nacc < 3; i++) begin
      step();
      if (mem_req && req_at == 0) req_at = i;
      if (if_valid && val_at == 0) val_at = i;
      if (just_acc) begin
        accs[nacc] = acc_addr;
        nacc++;
      end
    end
    chk("first_req_cycle", 32'(req_at + 1), 32'd2);
    chk("first_valid_cycle", 32'(val_at + 1), 32'd4);
    chk("n_accepts", 32'(nacc), 32'd3);
    for (int i = 0; i < 3; i++) chk("seq_addr", accs[i], 32'(i * 4));

    // 2: decode stalls in hold
    force_en = 1'b0; k_rdy = 1'b0;
    for (int i = 0; i < 20 && !if_valid; i++) step();
    chk("t2_valid", if_valid, 1'b1);
    hp = if_pc; hi = if_instr;
    repeat (5) begin
      step();
      chk("t2_pc_hold", if_pc, hp);
      chk("t2_instr_hold", if_instr, hi);
      chk("t2_no_req", mem_req, 1'b0);
    end
    k_rdy = 1'b1;
    step();
    for (int i = 0; i < 20 && !mem_req; i++) step();
    chk("t2_next_addr", mem_addr, hp + 32'd4);

    // 3: redirect while waiting; late response is dropped
    lat = 3; force_en = 1'b1; force_word = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !just_acc; i++) step();
    chk("t3_acc", just_acc, 1'b1);
    k_redir = 1'b1; k_tgt = 32'h0000_0103;
    step();
    for (int i = 0; i < 12 && !mem_req; i++) begin
      chk("t3_no_valid", if_valid, 1'b0);
      step();
    end
    chk("t3_valid_low", if_valid, 1'b0);
    chk("t3_req", mem_req, 1'b1);
    chk("t3_addr", mem_addr, 32'h0000_0100);

    // 4: end-of-program word halts; redirect resumes
    lat = 1; force_en = 1'b0; halt_en = 1'b1; halt_addr = 32'h10; k_rdy = 1'b1;
    k_redir = 1'b1; k_tgt = 32'h8;
    for (int i = 0; i < 40 && !halted; i++) step();
    chk("t4_halted", halted, 1'b1);
    repeat (4) begin
      step();
      chk("t4_no_req", mem_req, 1'b0);
      chk("t4_no_valid", if_valid, 1'b0);
    end
    k_redir = 1'b1; k_tgt = 32'h40;
    step();
    chk("t4_resume", halted, 1'b0);
    chk("t4_req", mem_req, 1'b1);
    chk("t4_addr", mem_addr, 32'h40);

    // 5: redirect coincident with decode accept flushes the held word
    halt_en = 1'b0; k_rdy = 1'b0;
    for (int i = 0; i < 20 && !if_valid; i++) step();
    chk("t5_valid", if_valid, 1'b1);
    k_redir = 1'b1; k_tgt = 32'h200; k_rdy = 1'b1;
    step();
    chk("t5_flush", if_valid, 1'b0);
    chk("t5_req", mem_req, 1'b1);
    chk("t5_addr", mem_addr, 32'h200);
    for (int i = 0; i < 20 && !if_valid; i++) step();
    chk("t5_pc", if_pc, 32'h200);

    // 6a: PC wraps at the top of the address space
    k_redir = 1'b1; k_tgt = 32'hFFFF_FFFC;
    step();
    for (int i = 0; i < 20 && !if_valid; i++) step();
    chk("t6_top_pc", if_pc, 32'hFFFF_FFFC);
    step();
    for (int i = 0; i < 20 && !mem_req; i++) step();
    chk("t6_wrap", mem_addr, 32'h0);

    // 6b: reset while waiting; response arriving after reset is ignored
    lat = 2; force_en = 1'b1; force_word = 32'h0000_0013;
    for (int i = 0; i < 20 && !just_acc; i++) step();
    chk("t6_acc", just_acc, 1'b1);
    k_rst_n = 1'b0;
    step();
    chk_reset_vals("midrst");
    k_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_late_rvalid", if_valid, 1'b0);
    end
    for (int i = 0; i < 10 && !if_valid; i++) step();
    chk("t6_refetch_pc", if_pc, 32'h0);

    // randomized phase against the model
    force_en = 1'b0; halt_en = 1'b1; halt_addr = 32'h3C;
    rdy_pct = 70; spur_pct = 10; rnd = 1'b1; n_beats = 0;
    repeat (3000) step();
    rnd = 1'b0;
    chk("rnd_progress", (n_beats > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
